nunchuck_i2c_responder: RTL and testbench

//  I2C target (responder) emulating a Wii Nunchuck at 7-bit address I2C_ADDR, the

---
 rtl/nunchuck_i2c_responder_if.sv | 10 +
 rtl/nunchuck_i2c_responder.sv | 202 ++++++++++++++++++++
 tb/tb_nunchuck_i2c_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nunchuck_i2c_responder_if.sv
// I2C pin bundle between a bus initiator model and the nunchuck responder.
// SDA is open-drain: the responder only asserts sda_drive_low.
interface nunchuck_i2c_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_drive_low;

  modport master (output scl_in, output sda_in, input sda_drive_low);
  modport slave  (input scl_in, input sda_in, output sda_drive_low);
endinterface

// File: rtl/nunchuck_i2c_responder.sv
// I2C target emulating a Wii Nunchuck: accepts init/pointer writes and serves the
// 6-byte report from a snapshot of the joystick, accelerometer and button inputs.
module nunchuck_i2c_responder #(
  parameter logic [6:0]  I2C_ADDR     = 7'h52,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SDA_HOLD_CYC = 4
) (
  input  logic                           clkin,
  input  logic                           rst,
  nunchuck_i2c_responder_if.slave        bus,
  input  logic [7:0]                     stick_x,
  input  logic [7:0]                     stick_y,
  input  logic [9:0]                     accel_x,
  input  logic [9:0]                     accel_y,
  input  logic [9:0]                     accel_z,
  input  logic                           z_btn,
  input  logic                           c_btn,
  output logic                           initialized,
  output logic                           busy,
  output logic                           xfer_done
);

  localparam int unsigned HW = $clog2(SDA_HOLD_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   start_det, stop_det, scl_rise, scl_fall;
  logic [HW-1:0]          hold_cnt;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic [7:0]             rx_byte;
  logic                   rw;
  logic                   first_byte;
  logic [7:0]             pointer;
  logic                   init_a, init_b;
  logic [7:0]             buffer [6];
  logic [7:0]             tx_byte;

  always_ff @(posedge clkin) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    scl_s     = scl_sync[SYNC_STAGES-1];
    sda_s     = sda_sync[SYNC_STAGES-1];
    start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    scl_rise  = scl_s & ~scl_prev;
    scl_fall  = ~scl_s & scl_prev;
    rx_byte   = {shift, sda_s};
    initialized = init_a & init_b;
  end

  always_comb begin
    tx_byte = 8'hFF;
    if (init_a && init_b) begin
      case (pointer)
        8'd0:    tx_byte = buffer[0];
        8'd1:    tx_byte = buffer[1];
        8'd2:    tx_byte = buffer[2];
        8'd3:    tx_byte = buffer[3];
        8'd4:    tx_byte = buffer[4];
        8'd5:    tx_byte = buffer[5];
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  // Bits are consumed on SCL rise; the SDA level for the next bit is chosen
  // from the post-rise state once the hold delay after the following fall expires.
  always_ff @(posedge clkin) begin
    if (!rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      rw            <= 1'b0;
      first_byte    <= 1'b0;
      pointer       <= '0;
      init_a        <= 1'b0;
      init_b        <= 1'b0;
      busy          <= 1'b0;
      xfer_done     <= 1'b0;
      bus.sda_drive_low <= 1'b0;
      hold_cnt      <= '0;
      for (int unsigned i = 0; i < 6; i++) buffer[i] <= '0;
    end else begin
      xfer_done <= 1'b0;
      if (stop_det) begin
        state             <= IDLE;
        bus.sda_drive_low <= 1'b0;
        hold_cnt          <= '0;
        xfer_done         <= busy;
        busy              <= 1'b0;
      end else if (start_det) begin
        state             <= ADDR;
        bit_cnt           <= '0;
        bus.sda_drive_low <= 1'b0;
        hold_cnt          <= '0;
      end else begin
        if (scl_fall) begin
          hold_cnt <= HW'(SDA_HOLD_CYC);
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt == HW'(1)) begin
            case (state)
              ADDR_ACK, WR_ACK: bus.sda_drive_low <= 1'b1;
              RD_BYTE:          bus.sda_drive_low <= ~tx_byte[~bit_cnt];
              default:          bus.sda_drive_low <= 1'b0;
            endcase
          end
        end

        if (scl_rise) begin
          case (state)
            ADDR: begin
              shift <= {shift[5:0], sda_s};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (shift == I2C_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= sda_s;
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            ADDR_ACK: begin
              bit_cnt <= '0;
              if (rw) begin
                buffer[0] <= stick_x;
                buffer[1] <= stick_y;
                buffer[2] <= accel_x[9:2];
                buffer[3] <= accel_y[9:2];
                buffer[4] <= accel_z[9:2];
                buffer[5] <= {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c_btn, ~z_btn};
                state     <= RD_BYTE;
              end else begin
                first_byte <= 1'b1;
                state      <= WR_BYTE;
              end
            end
            WR_BYTE: begin
              shift <= {shift[5:0], sda_s};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                state   <= WR_ACK;
                if (first_byte) begin
                  pointer    <= rx_byte;
                  first_byte <= 1'b0;
                end else begin
                  if (pointer == 8'hF0 && rx_byte == 8'h55) init_a <= 1'b1;
                  if (pointer == 8'hFB && rx_byte == 8'h00) init_b <= 1'b1;
                  pointer <= pointer + 8'd1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            WR_ACK: state <= WR_BYTE;
            RD_BYTE: begin
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                state   <= RD_MACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            RD_MACK: begin
              if (!sda_s) begin
                pointer <= (pointer == 8'd5) ? 8'd0 : pointer + 8'd1;
                state   <= RD_BYTE;
              end else begin
                state <= IGNORE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nunchuck_i2c_responder.sv
// Bench for nunchuck_i2c_responder: bit-banged I2C initiator plus a transaction-level
// model of the pointer, init flags and report bytes.
module tb_nunchuck_i2c_responder;

  localparam int         Q        = 80;
  localparam logic [6:0] DUT_ADDR = 7'h52;

  logic       clkin = 1'b0;
  logic       rst   = 1'b0;
  logic       m_sda = 1'b1;
  logic [7:0] stick_x = '0, stick_y = '0;
  logic [9:0] accel_x = '0, accel_y = '0, accel_z = '0;
  logic       z_btn = 1'b0, c_btn = 1'b0;
  logic       initialized, busy, xfer_done;

  always #5 clkin = ~clkin;

  nunchuck_i2c_responder_if bus ();
  assign bus.sda_in = m_sda & ~bus.sda_drive_low;

  nunchuck_i2c_responder #(
    .I2C_ADDR     (DUT_ADDR),
    .SYNC_STAGES  (2),
    .SDA_HOLD_CYC (4)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .bus         (bus),
    .stick_x     (stick_x),
    .stick_y     (stick_y),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .z_btn       (z_btn),
    .c_btn       (c_btn),
    .initialized (initialized),
    .busy        (busy),
    .xfer_done   (xfer_done)
  );

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int drv_cnt    = 0;
  int busy_cnt   = 0;

  always @(posedge clkin) begin
    if (xfer_done === 1'b1)         done_cnt = done_cnt + 1;
    if (bus.sda_drive_low === 1'b1) drv_cnt  = drv_cnt + 1;
    if (busy === 1'b1)              busy_cnt = busy_cnt + 1;
  end

  // Reference model state
  logic [7:0] m_ptr    = '0;
  bit         m_init_a = 0;
  bit         m_init_b = 0;
  logic [7:0] wq[$];
  int         change_at = -1;
  logic [7:0] new_sx    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wbit(input logic b);
    m_sda = b;      #Q;
    bus.scl_in = 1; #(2*Q);
    bus.scl_in = 0; #Q;
  endtask

  task automatic rbit(output logic b);
    m_sda = 1;      #Q;
    bus.scl_in = 1; #Q;
    b = bus.sda_in; #Q;
    bus.scl_in = 0; #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1;      #Q;
    bus.scl_in = 1; #Q;
    m_sda = 0;      #Q;
    bus.scl_in = 0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 0;      #Q;
    bus.scl_in = 1; #Q;
    m_sda = 1;      #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack ? 1'b0 : 1'b1);
  endtask

  task automatic model_wr(input int idx, input logic [7:0] d);
    if (idx == 0) m_ptr = d;
    else begin
      if (m_ptr == 8'hF0 && d == 8'h55) m_init_a = 1;
      if (m_ptr == 8'hFB && d == 8'h00) m_init_b = 1;
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic model_reset();
    m_ptr = '0; m_init_a = 0; m_init_b = 0;
  endtask

  task automatic do_write(input logic [6:0] addr);
    logic ack;
    bit   match;
    match = (addr == DUT_ADDR);
    i2c_start();
    write_byte({addr, 1'b0}, ack);
    check("wr_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
    foreach (wq[i]) begin
      write_byte(wq[i], ack);
      check($sformatf("wr_data_ack%0d", i), 32'(ack), match ? 32'd0 : 32'd1);
      if (match) model_wr(i, wq[i]);
    end
    i2c_stop();
  endtask

  task automatic do_read(input int n);
    logic       ack;
    logic [7:0] d, e;
    logic [7:0] snap [6];
    int         b5;
    snap[0] = stick_x;
    snap[1] = stick_y;
    snap[2] = 8'(accel_x / 4);
    snap[3] = 8'(accel_y / 4);
    snap[4] = 8'(accel_z / 4);
    b5 = (accel_z % 4) * 64 + (accel_y % 4) * 16 + (accel_x % 4) * 4
       + (c_btn ? 0 : 2) + (z_btn ? 0 : 1);
    snap[5] = 8'(b5);
    i2c_start();
    write_byte({DUT_ADDR, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    check("busy_in_read", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      e = (m_init_a && m_init_b && m_ptr < 8'd6) ? snap[m_ptr[2:0]] : 8'hFF;
      check($sformatf("rd_byte%0d", i), 32'(d), 32'(e));
      if (i < n - 1) m_ptr = (m_ptr == 8'd5) ? 8'd0 : m_ptr + 8'd1;
      if (i == change_at) stick_x = new_sx;
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic do_init();
    int d0;
    d0 = done_cnt;
    wq = '{8'hF0, 8'h55};
    do_write(DUT_ADDR);
    check("init_half", 32'(initialized), 32'(m_init_a && m_init_b));
    wq = '{8'hFB, 8'h00};
    do_write(DUT_ADDR);
    check("init_full", 32'(initialized), 32'(m_init_a && m_init_b));
    check("init_done_pulses", 32'(done_cnt - d0), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0, v0, b0;
    logic       b;
    logic [7:0] d, old_sx;

    bus.scl_in = 1'b1;
    m_sda      = 1'b1;
    rst        = 1'b0;
    repeat (4) @(negedge clkin);
    check("rst_drive",  32'(bus.sda_drive_low), 32'd0);
    check("rst_init",   32'(initialized), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(xfer_done), 32'd0);
    rst = 1'b1;
    #Q;

    // Read before init: all 0xFF
    stick_x = 8'($urandom); stick_y = 8'($urandom);
    accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
    do_read(6);
    check("uninit_flag", 32'(initialized), 32'd0);

    // Foreign address: never driven, never busy, no done pulse
    d0 = done_cnt; v0 = drv_cnt; b0 = busy_cnt;
    wq = '{8'hF0, 8'h55};
    do_write(7'h53);
    check("foreign_drive", 32'(drv_cnt - v0), 32'd0);
    check("foreign_busy",  32'(busy_cnt - b0), 32'd0);
    check("foreign_done",  32'(done_cnt - d0), 32'd0);
    check("foreign_init",  32'(initialized), 32'd0);

    do_init();

    // Directed report values
    stick_x = 8'h80; stick_y = 8'h7F;
    accel_x = 10'h201; accel_y = 10'h1FE; accel_z = 10'h3FF;
    z_btn = 1'b1; c_btn = 1'b0;
    wq = '{8'h00};
    do_write(DUT_ADDR);
    d0 = done_cnt;
    do_read(6);
    check("read_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Wrap 5->0 and mid-burst input change held off by the snapshot
    stick_x = 8'($urandom); stick_y = 8'($urandom);
    accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
    z_btn = 1'($urandom); c_btn = 1'($urandom);
    old_sx = stick_x;
    new_sx = ~old_sx;
    wq = '{8'h00};
    do_write(DUT_ADDR);
    change_at = 1;
    do_read(8);
    change_at = -1;
    check("sx_changed", 32'(stick_x), 32'(new_sx));
    wq = '{8'h00};
    do_write(DUT_ADDR);
    do_read(1);

    // Randomized pointer/length reads and stray register writes
    for (int r = 0; r < 6; r++) begin
      stick_x = 8'($urandom); stick_y = 8'($urandom);
      accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
      z_btn = 1'($urandom); c_btn = 1'($urandom);
      wq = '{8'($urandom_range(0, 7))};
      if (r % 3 == 2) wq.push_back(8'($urandom));
      do_write(DUT_ADDR);
      if (r % 3 == 2) begin
        wq = '{8'($urandom_range(0, 7))};
        do_write(DUT_ADDR);
      end
      do_read($urandom_range(1, 8));
    end
    check("init_kept", 32'(initialized), 32'(m_init_a && m_init_b));

    // Reset while the responder drives a bit of byte 2
    accel_x = 10'h000;
    wq = '{8'h00};
    do_write(DUT_ADDR);
    i2c_start();
    write_byte({DUT_ADDR, 1'b1}, b);
    check("rst_case_addr_ack", 32'(b), 32'd0);
    read_byte(1'b1, d);
    read_byte(1'b1, d);
    for (int i = 0; i < 4; i++) rbit(b);
    m_sda = 1'b1;
    #(Q/2);
    check("pre_reset_drive", 32'(bus.sda_drive_low), 32'd1);
    @(negedge clkin);
    rst = 1'b0;
    @(posedge clkin);
    #1;
    check("mid_reset_drive", 32'(bus.sda_drive_low), 32'd0);
    check("mid_reset_init",  32'(initialized), 32'd0);
    check("mid_reset_busy",  32'(busy), 32'd0);
    model_reset();
    @(negedge clkin);
    bus.scl_in = 1'b1;
    repeat (3) @(negedge clkin);
    rst = 1'b1;
    #Q;

    stick_x = 8'($urandom); stick_y = 8'($urandom);
    accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
    z_btn = 1'($urandom); c_btn = 1'($urandom);
    do_init();
    wq = '{8'h00};
    do_write(DUT_ADDR);
    do_read(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
